score_keeper: RTL and testbench



---
 rtl/pong_pkg.sv | 33 +++
 rtl/edge_rise.sv | 35 +++
 rtl/score_keeper.sv | 191 +++++++++++++++++++
 tb/tb_score_keeper.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong score keeper.
// Contents:
//   score_state_t      - serve hold-off / play / game-over state encoding
//   POINTS_W           - width of one displayed score nibble
//   MAX_DISPLAY_POINTS - largest value the 7-segment display can show
//   sat_inc            - saturating score increment
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE_WAIT = 2'd0,
        PLAY       = 2'd1,
        GAME_OVER  = 2'd2
    } score_state_t;

    localparam int POINTS_W           = 4;
    localparam int MAX_DISPLAY_POINTS = 9;

    // Increment a score but never past lim, so the nibble can never wrap
    // or leave the displayable range.
    function automatic logic [POINTS_W-1:0] sat_inc(
        input logic [POINTS_W-1:0] pts,
        input logic [POINTS_W-1:0] lim
    );
        logic [POINTS_W-1:0] res;
        if (pts >= lim) begin
            res = lim;
        end else begin
            res = pts + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector with a registered history bit.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (clears history)
//   in   - level input
//   rise - high for the cycle where in is high and was low last cycle
// The history is cleared by reset, so an input that is already high when
// reset releases is reported as an edge on the first cycle out of reset.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q;
    logic in_d;

    // Next history value is simply the current input level.
    always_comb begin
        in_d = in;
    end

    // History register, updated every cycle regardless of consumer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/score_keeper.sv
// Score keeper for the pong game.
// Turns goal events into saturating per-player scores, holds the ball
// still for a serve hold-off after every goal, and freezes the final score
// once a player reaches WIN_POINTS until a new game is requested.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   goal_first/second     - goal indications, rising edge counts
//   new_game              - restart request, rising edge counts in GAME_OVER only
//   points_first_player   - first player score nibble
//   points_second_player  - second player score nibble
//   serve_en              - ball may move (PLAY state)
//   game_over             - final score is being held
//   winner                - 0 first player, 1 second player (valid with game_over)
// All outputs come straight from flops.
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_POINTS  = 9,
    parameter int HOLD_CYCLES = 65_000_000,
    parameter int HOLD_W      = 27
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                goal_first,
    input  logic                goal_second,
    input  logic                new_game,
    output logic [POINTS_W-1:0] points_first_player,
    output logic [POINTS_W-1:0] points_second_player,
    output logic                serve_en,
    output logic                game_over,
    output logic                winner
);

    // Clamp the win score to what the display can show.
    localparam int WIN_LIM = (WIN_POINTS > MAX_DISPLAY_POINTS) ?
                             MAX_DISPLAY_POINTS : WIN_POINTS;
    localparam logic [POINTS_W-1:0] WIN_P     = POINTS_W'(WIN_LIM);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic rise_first;
    logic rise_second;
    logic rise_new_game;

    edge_rise u_edge_first (
        .clk  (clk),
        .rst  (rst),
        .in   (goal_first),
        .rise (rise_first)
    );

    edge_rise u_edge_second (
        .clk  (clk),
        .rst  (rst),
        .in   (goal_second),
        .rise (rise_second)
    );

    edge_rise u_edge_new_game (
        .clk  (clk),
        .rst  (rst),
        .in   (new_game),
        .rise (rise_new_game)
    );

    score_state_t        state_q,     state_d;
    logic [HOLD_W-1:0]   cnt_q,       cnt_d;
    logic [POINTS_W-1:0] pts_first_q, pts_first_d;
    logic [POINTS_W-1:0] pts_second_q, pts_second_d;
    logic                serve_en_q,  serve_en_d;
    logic                game_over_q, game_over_d;
    logic                winner_q,    winner_d;
    logic [POINTS_W-1:0] inc_first_s;
    logic [POINTS_W-1:0] inc_second_s;

    // Candidate scores if the corresponding player scores this cycle.
    always_comb begin
        inc_first_s  = sat_inc(pts_first_q, WIN_P);
        inc_second_s = sat_inc(pts_second_q, WIN_P);
    end

    // Next-state, counter and output logic; everything holds by default.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pts_first_d  = pts_first_q;
        pts_second_d = pts_second_q;
        serve_en_d   = serve_en_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;

        case (state_q)
            SERVE_WAIT: begin
                serve_en_d  = 1'b0;
                game_over_d = 1'b0;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d      = {HOLD_W{1'b0}};
                    state_d    = PLAY;
                    serve_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end

            PLAY: begin
                serve_en_d  = 1'b1;
                game_over_d = 1'b0;
                if (rise_first && rise_second) begin
                    // Simultaneous goals: nobody scores, serve is replayed.
                    state_d    = SERVE_WAIT;
                    cnt_d      = {HOLD_W{1'b0}};
                    serve_en_d = 1'b0;
                end else if (rise_first) begin
                    pts_first_d = inc_first_s;
                    serve_en_d  = 1'b0;
                    cnt_d       = {HOLD_W{1'b0}};
                    if (inc_first_s == WIN_P) begin
                        state_d     = GAME_OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b0;
                    end else begin
                        state_d = SERVE_WAIT;
                    end
                end else if (rise_second) begin
                    pts_second_d = inc_second_s;
                    serve_en_d   = 1'b0;
                    cnt_d        = {HOLD_W{1'b0}};
                    if (inc_second_s == WIN_P) begin
                        state_d     = GAME_OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b1;
                    end else begin
                        state_d = SERVE_WAIT;
                    end
                end else begin
                    state_d = PLAY;
                end
            end

            GAME_OVER: begin
                serve_en_d  = 1'b0;
                game_over_d = 1'b1;
                if (rise_new_game) begin
                    pts_first_d  = {POINTS_W{1'b0}};
                    pts_second_d = {POINTS_W{1'b0}};
                    game_over_d  = 1'b0;
                    winner_d     = 1'b0;
                    cnt_d        = {HOLD_W{1'b0}};
                    state_d      = SERVE_WAIT;
                end else begin
                    state_d = GAME_OVER;
                end
            end

            default: begin
                // Unreachable encoding: restart the serve hold-off.
                state_d     = SERVE_WAIT;
                cnt_d       = {HOLD_W{1'b0}};
                serve_en_d  = 1'b0;
                game_over_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SERVE_WAIT;
            cnt_q        <= {HOLD_W{1'b0}};
            pts_first_q  <= {POINTS_W{1'b0}};
            pts_second_q <= {POINTS_W{1'b0}};
            serve_en_q   <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pts_first_q  <= pts_first_d;
            pts_second_q <= pts_second_d;
            serve_en_q   <= serve_en_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    assign points_first_player  = pts_first_q;
    assign points_second_player = pts_second_q;
    assign serve_en             = serve_en_q;
    assign game_over            = game_over_q;
    assign winner               = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with HOLD_CYCLES=4, WIN_POINTS=3.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_score_keeper;

    logic       clk;
    logic       rst;
    logic       goal_first;
    logic       goal_second;
    logic       new_game;
    logic [3:0] points_first_player;
    logic [3:0] points_second_player;
    logic       serve_en;
    logic       game_over;
    logic       winner;

    int total = 0;
    int bad   = 0;

    score_keeper #(
        .WIN_POINTS  (3),
        .HOLD_CYCLES (4),
        .HOLD_W      (3)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .goal_first           (goal_first),
        .goal_second          (goal_second),
        .new_game             (new_game),
        .points_first_player  (points_first_player),
        .points_second_player (points_second_player),
        .serve_en             (serve_en),
        .game_over            (game_over),
        .winner               (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] p1, input logic [3:0] p2,
                             input logic se, input logic go, input logic w);
        check({tag, ".p1"}, points_first_player, p1);
        check({tag, ".p2"}, points_second_player, p2);
        check({tag, ".serve_en"}, {3'd0, serve_en}, {3'd0, se});
        check({tag, ".game_over"}, {3'd0, game_over}, {3'd0, go});
        check({tag, ".winner"}, {3'd0, winner}, {3'd0, w});
    endtask

    // Called right after the edge that entered SERVE_WAIT was sampled:
    // three more low samples, then serve_en rises on the fourth edge.
    task automatic holdoff(input string tag);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check({tag, ".hold_low"}, {3'd0, serve_en}, 4'd0);
        end
        tick(1);
        check({tag, ".hold_high"}, {3'd0, serve_en}, 4'd1);
    endtask

    task automatic pulse_first();
        goal_first = 1'b1;
        tick(1);
        goal_first = 1'b0;
    endtask

    task automatic pulse_second();
        goal_second = 1'b1;
        tick(1);
        goal_second = 1'b0;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick(1);
        new_game = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        goal_first  = 1'b0;
        goal_second = 1'b0;
        new_game    = 1'b0;
        tick(2);
        check_all("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Start-up hold-off.
        rst = 1'b0;
        holdoff("startup");
        check_all("startup_play", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Single first-player goal; a goal edge during hold-off is ignored.
        pulse_first();
        check_all("goal1", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check("hold_ign.se1", {3'd0, serve_en}, 4'd0);
        goal_first = 1'b1;
        tick(1);
        goal_first = 1'b0;
        check("hold_ign.p1", points_first_player, 4'd1);
        check("hold_ign.se2", {3'd0, serve_en}, 4'd0);
        tick(1);
        check("hold_ign.se3", {3'd0, serve_en}, 4'd0);
        tick(1);
        check("hold_ign.se4", {3'd0, serve_en}, 4'd1);

        // goal_second held for 20 cycles counts once.
        goal_second = 1'b1;
        tick(1);
        check_all("level2", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        holdoff("level2");
        tick(15);
        check_all("level2_held", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
        goal_second = 1'b0;
        tick(1);

        // Both goals on the same edge: replayed serve, no score change.
        goal_first  = 1'b1;
        goal_second = 1'b1;
        tick(1);
        goal_first  = 1'b0;
        goal_second = 1'b0;
        check_all("both", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        holdoff("both");

        // First player to 3 ends the game.
        pulse_first();
        check_all("goal1_2", 4'd2, 4'd1, 1'b0, 1'b0, 1'b0);
        holdoff("goal1_2");
        pulse_first();
        check_all("win1", 4'd3, 4'd1, 1'b0, 1'b1, 1'b0);
        tick(1);
        pulse_first();
        pulse_second();
        tick(6);
        check_all("frozen", 4'd3, 4'd1, 1'b0, 1'b1, 1'b0);

        // New game clears everything and restarts the hold-off.
        pulse_new_game();
        check_all("newgame", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        holdoff("newgame");

        // Second player wins 2/3.
        pulse_second();
        holdoff("g_a");
        pulse_first();
        holdoff("g_b");
        pulse_second();
        holdoff("g_c");
        pulse_first();
        holdoff("g_d");
        pulse_second();
        check_all("win2", 4'd2, 4'd3, 1'b0, 1'b1, 1'b1);
        tick(2);

        // Reset from GAME_OVER.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_all("rst_go", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        holdoff("rst_go");

        // new_game in PLAY is ignored.
        pulse_first();
        holdoff("pre_ng");
        pulse_new_game();
        tick(2);
        check_all("ng_play", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
